// File: rtl/pixel_stream_unpacker.sv
// Receive-side unpacker for the generated video stream.
// Three 32-bit words carry four 24-bit RGB pixels; the block emits one pixel
// per handshake with its x/y position, checks frame framing (tuser on the
// first word, tlast on the last word of each line) and keeps saturating
// frame / error counters.
module pixel_stream_unpacker #(
   parameter int X_SIZE = 640,
   parameter int Y_SIZE = 480
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] in_stream_tdata,
   input  logic [3:0]  in_stream_tkeep,
   input  logic        in_stream_tlast,
   input  logic        in_stream_tuser,
   input  logic        in_stream_tvalid,
   output logic        in_stream_tready,
   output logic [7:0]  pix_r,
   output logic [7:0]  pix_g,
   output logic [7:0]  pix_b,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        pix_sof,
   output logic        pix_eol,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [15:0] frame_count,
   output logic [15:0] sof_err_count,
   output logic [15:0] eol_err_count,
   output logic        locked
);

   localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
   localparam logic [9:0] X_PEN  = 10'(X_SIZE - 2);
   localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

   typedef enum logic [0:0] {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Saturating event counter increment.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t      state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic [23:0] hold_q, hold_d;
   logic [9:0]  x_q, x_d;
   logic [8:0]  y_q, y_d;
   logic [23:0] pix_rgb_q, pix_rgb_d;
   logic [9:0]  pix_x_q, pix_x_d;
   logic [8:0]  pix_y_q, pix_y_d;
   logic        pix_sof_q, pix_sof_d;
   logic        pix_eol_q, pix_eol_d;
   logic        pix_valid_q, pix_valid_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic [15:0] sof_err_q, sof_err_d;
   logic [15:0] eol_err_q, eol_err_d;
   logic        locked_q, locked_d;

   logic        advance_s;
   logic        tready_s;
   logic        accept_s;
   logic        exp_sof_s;
   logic        exp_eol_s;
   logic        emit_s;
   logic [23:0] emit_pix_s;
   logic [9:0]  pos_x_s;
   logic [8:0]  pos_y_s;
   logic        unpack_s;
   logic [1:0]  unpack_phase_s;
   logic        unused_s;

   // tkeep is always all-ones from the source and carries no information.
   assign unused_s = ^in_stream_tkeep;

   // The output register can take a new pixel when empty or being drained.
   assign advance_s = !pix_valid_q || pix_ready;
   // No word is taken while the held phase-3 pixel is still to be emitted.
   assign tready_s  = aresetn && (phase_q != 2'd3) && advance_s;
   assign accept_s  = in_stream_tvalid && tready_s;
   // Framing expectations for the word currently offered.
   assign exp_sof_s = (phase_q == 2'd0) && (x_q == 10'd0) && (y_q == 9'd0);
   assign exp_eol_s = (phase_q == 2'd2) && (x_q == X_PEN);

   // Next-state logic: hunting, unpacking, framing checks and position tracking.
   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      hold_d         = hold_q;
      x_d            = x_q;
      y_d            = y_q;
      pix_rgb_d      = pix_rgb_q;
      pix_x_d        = pix_x_q;
      pix_y_d        = pix_y_q;
      pix_sof_d      = pix_sof_q;
      pix_eol_d      = pix_eol_q;
      pix_valid_d    = pix_valid_q;
      frame_count_d  = frame_count_q;
      sof_err_d      = sof_err_q;
      eol_err_d      = eol_err_q;
      emit_s         = 1'b0;
      emit_pix_s     = 24'h000000;
      pos_x_s        = x_q;
      pos_y_s        = y_q;
      unpack_s       = 1'b0;
      unpack_phase_s = phase_q;

      if (advance_s) begin
         pix_valid_d = 1'b0;
      end else begin
         pix_valid_d = pix_valid_q;
      end

      case (state_q)
         ST_HUNT: begin
            if (accept_s && in_stream_tuser) begin
               // Start-of-frame word: it is w0 of pixel (0,0).
               state_d        = ST_LOCKED;
               pos_x_s        = 10'd0;
               pos_y_s        = 9'd0;
               unpack_s       = 1'b1;
               unpack_phase_s = 2'd0;
            end else begin
               state_d = ST_HUNT;
            end
         end
         ST_LOCKED: begin
            if (phase_q == 2'd3) begin
               if (advance_s) begin
                  emit_s     = 1'b1;
                  emit_pix_s = hold_q;
                  phase_d    = 2'd0;
               end else begin
                  phase_d = phase_q;
               end
            end else if (accept_s) begin
               if (in_stream_tlast != exp_eol_s) begin
                  eol_err_d = sat_inc(eol_err_q);
               end else begin
                  eol_err_d = eol_err_q;
               end
               if (exp_sof_s && !in_stream_tuser) begin
                  // Missing start of frame: drop the word and re-hunt.
                  sof_err_d = sat_inc(sof_err_q);
                  state_d   = ST_HUNT;
                  phase_d   = 2'd0;
               end else if (!exp_sof_s && in_stream_tuser) begin
                  // Unexpected start of frame: abandon the partial frame.
                  sof_err_d      = sat_inc(sof_err_q);
                  pos_x_s        = 10'd0;
                  pos_y_s        = 9'd0;
                  unpack_s       = 1'b1;
                  unpack_phase_s = 2'd0;
               end else begin
                  unpack_s = 1'b1;
               end
            end else begin
               phase_d = phase_q;
            end
         end
         default: begin
            state_d = ST_HUNT;
            phase_d = 2'd0;
         end
      endcase

      if (unpack_s) begin
         case (unpack_phase_s)
            2'd0: begin
               emit_s     = 1'b1;
               emit_pix_s = in_stream_tdata[23:0];
               hold_d     = {16'h0000, in_stream_tdata[31:24]};
               phase_d    = 2'd1;
            end
            2'd1: begin
               emit_s     = 1'b1;
               emit_pix_s = {in_stream_tdata[15:0], hold_q[7:0]};
               hold_d     = {8'h00, in_stream_tdata[31:16]};
               phase_d    = 2'd2;
            end
            2'd2: begin
               emit_s     = 1'b1;
               emit_pix_s = {in_stream_tdata[7:0], hold_q[15:0]};
               hold_d     = in_stream_tdata[31:8];
               phase_d    = 2'd3;
            end
            default: begin
               emit_s  = 1'b0;
               phase_d = phase_q;
            end
         endcase
      end else begin
         hold_d = hold_d;
      end

      if (emit_s) begin
         pix_valid_d = 1'b1;
         pix_rgb_d   = emit_pix_s;
         pix_x_d     = pos_x_s;
         pix_y_d     = pos_y_s;
         pix_sof_d   = (pos_x_s == 10'd0) && (pos_y_s == 9'd0);
         pix_eol_d   = (pos_x_s == X_LAST);
         if (pos_x_s == X_LAST) begin
            x_d = 10'd0;
            if (pos_y_s == Y_LAST) begin
               y_d           = 9'd0;
               frame_count_d = sat_inc(frame_count_q);
            end else begin
               y_d = pos_y_s + 9'd1;
            end
         end else begin
            x_d = pos_x_s + 10'd1;
            y_d = pos_y_s;
         end
      end else begin
         x_d = x_q;
         y_d = y_q;
      end

      locked_d = (state_d == ST_LOCKED);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q       <= ST_HUNT;
         phase_q       <= 2'd0;
         hold_q        <= 24'h000000;
         x_q           <= 10'd0;
         y_q           <= 9'd0;
         pix_rgb_q     <= 24'h000000;
         pix_x_q       <= 10'd0;
         pix_y_q       <= 9'd0;
         pix_sof_q     <= 1'b0;
         pix_eol_q     <= 1'b0;
         pix_valid_q   <= 1'b0;
         frame_count_q <= 16'h0000;
         sof_err_q     <= 16'h0000;
         eol_err_q     <= 16'h0000;
         locked_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         hold_q        <= hold_d;
         x_q           <= x_d;
         y_q           <= y_d;
         pix_rgb_q     <= pix_rgb_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_sof_q     <= pix_sof_d;
         pix_eol_q     <= pix_eol_d;
         pix_valid_q   <= pix_valid_d;
         frame_count_q <= frame_count_d;
         sof_err_q     <= sof_err_d;
         eol_err_q     <= eol_err_d;
         locked_q      <= locked_d;
      end
   end

   assign in_stream_tready = tready_s;
   assign pix_r            = pix_rgb_q[23:16];
   assign pix_g            = pix_rgb_q[15:8];
   assign pix_b            = pix_rgb_q[7:0];
   assign pix_x            = pix_x_q;
   assign pix_y            = pix_y_q;
   assign pix_sof          = pix_sof_q;
   assign pix_eol          = pix_eol_q;
   assign pix_valid        = pix_valid_q;
   assign frame_count      = frame_count_q;
   assign sof_err_count    = sof_err_q;
   assign eol_err_count    = eol_err_q;
   assign locked           = locked_q;

endmodule

// File: tb/tb_pixel_stream_unpacker.sv
// Directed bench for pixel_stream_unpacker on a reduced 8x2 frame.
module tb_pixel_stream_unpacker;

   localparam int XS  = 8;
   localparam int YS  = 2;
   localparam int WPL = 6;
   localparam int WPF = 12;
   localparam int PPF = 16;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] tdata = 32'h0;
   logic [3:0]  tkeep = 4'hF;
   logic        tlast = 1'b0;
   logic        tuser = 1'b0;
   logic        tvalid = 1'b0;
   logic        tready;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic        pix_sof, pix_eol, pix_valid;
   logic        pix_ready = 1'b1;
   logic [15:0] frame_count, sof_err_count, eol_err_count;
   logic        locked;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int stall_cycles = 0;
   bit rand_mode = 1'b0;

   typedef struct {
      logic [23:0] rgb;
      logic [9:0]  x;
      logic [8:0]  y;
      logic        sof;
      logic        eol;
      int          cyc;
   } pix_t;
   pix_t q[$];

   typedef struct {
      logic [31:0] w0, w1, w2;
      logic [23:0] p0, p1, p2, p3;
   } vec_t;
   vec_t tbl[4];

   pixel_stream_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
      .aclk(clk), .aresetn(aresetn),
      .in_stream_tdata(tdata), .in_stream_tkeep(tkeep),
      .in_stream_tlast(tlast), .in_stream_tuser(tuser),
      .in_stream_tvalid(tvalid), .in_stream_tready(tready),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .frame_count(frame_count), .sof_err_count(sof_err_count),
      .eol_err_count(eol_err_count), .locked(locked)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Downstream ready: changes at the falling edge only.
   initial forever begin
      @(negedge clk);
      pix_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   // Pixel collector plus output-hold check while stalled.
   initial begin
      logic        stall_prev;
      logic [63:0] saved;
      logic [63:0] now;
      stall_prev = 1'b0;
      saved = 64'h0;
      forever begin
         @(negedge clk);
         #2;
         now = {pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol};
         if (stall_prev) chk("hold_while_stalled", now[31:0] ^ saved[31:0] ^ {31'h0, now[63:32] != saved[63:32]}, 32'h0);
         if (pix_valid && pix_ready) q.push_back('{{pix_r, pix_g, pix_b}, pix_x, pix_y, pix_sof, pix_eol, cyc});
         stall_prev = pix_valid && !pix_ready;
         saved = now;
      end
   end

   function automatic logic [23:0] gpix(input int seed, input int x, input int y);
      return {8'(seed * 3 + x), 8'(y * 16 + x + seed), 8'(8'hA5 ^ 8'(seed + x + y))};
   endfunction

   function automatic logic [31:0] gword(input int seed, input int wi);
      int g, k, idx, x0, y0;
      logic [23:0] p0, p1, p2, p3;
      g = wi / 3; k = wi % 3; idx = 4 * g; x0 = idx % XS; y0 = idx / XS;
      p0 = gpix(seed, x0, y0);     p1 = gpix(seed, x0 + 1, y0);
      p2 = gpix(seed, x0 + 2, y0); p3 = gpix(seed, x0 + 3, y0);
      case (k)
         0:       return {p1[7:0], p0};
         1:       return {p2[15:0], p1[23:8]};
         default: return {p3, p2[23:16]};
      endcase
   endfunction

   // Offer one word and wait (bounded) until it is taken.
   task automatic send(input logic [31:0] d, input logic u, input logic l);
      bit acc;
      tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < 60 && !acc; n++) begin
         @(negedge clk);
         #1;
         acc = tready;
         if (!acc) stall_cycles++;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         checks++; errors++;
         $display("FAIL tready_timeout: got 0 expected 1");
      end
   endtask

   task automatic idle();
      tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
   endtask

   task automatic send_frame(input int seed, input int nwords, input bit fault);
      logic l;
      for (int wi = 0; wi < nwords; wi++) begin
         l = (wi % WPL) == WPL - 1;
         if (fault && wi == 5) l = 1'b0;
         if (fault && wi == 8) l = 1'b1;
         send(gword(seed, wi), wi == 0, l);
      end
      idle();
   endtask

   task automatic drain(input int want);
      for (int t = 0; t < 300 && q.size() < want; t++) @(posedge clk);
      repeat (6) @(posedge clk);
      #3;
   endtask

   task automatic check_frame(input int seed);
      drain(PPF);
      chk("frame_pixel_count", q.size(), PPF);
      for (int i = 0; i < q.size() && i < PPF; i++) begin
         chk("frame_rgb", q[i].rgb, gpix(seed, i % XS, i / XS));
         chk("frame_x", q[i].x, i % XS);
         chk("frame_y", q[i].y, i / XS);
         chk("frame_sof", q[i].sof, i == 0);
         chk("frame_eol", q[i].eol, (i % XS) == XS - 1);
      end
      q.delete();
   endtask

   task automatic do_reset();
      idle();
      aresetn = 1'b0;
      @(posedge clk); #1;
      chk("rst_tready", tready, 0);
      @(posedge clk); #1;
      chk("rst_tready2", tready, 0);
      chk("rst_valid", pix_valid, 0);
      chk("rst_rgb_xy", {pix_r, pix_g, pix_b, pix_sof, pix_eol}, 0);
      chk("rst_x", pix_x, 0);
      chk("rst_y", pix_y, 0);
      chk("rst_counts", {frame_count, sof_err_count}, 0);
      chk("rst_eol_count", eol_err_count, 0);
      chk("rst_locked", locked, 0);
      aresetn = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      tbl[0] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 24'h332211, 24'h665544, 24'h998877, 24'hCCBBAA};
      tbl[1] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 24'h020100, 24'h050403, 24'h080706, 24'h0B0A09};
      tbl[2] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 24'hADBEEF, 24'h4567DE, 24'hEF0123, 24'h89ABCD};
      tbl[3] = '{32'hFFFFFFFF, 32'h00000000, 32'hFF00FF00, 24'hFFFFFF, 24'h0000FF, 24'h000000, 24'hFF00FF};

      do_reset();

      // Words without tuser while hunting are dropped.
      for (int i = 0; i < 5; i++) send(32'h1000 + 32'(i), 1'b0, i == 2);
      idle();
      drain(1);
      chk("hunt_no_pixels", q.size(), 0);
      chk("hunt_locked", locked, 0);
      chk("hunt_sof_err", sof_err_count, 0);

      // Hand-computed packing table as one full frame.
      stall_cycles = 0;
      for (int g = 0; g < 4; g++) begin
         send(tbl[g].w0, g == 0, 1'b0);
         if (g == 0) chk("locked_on_tuser", locked, 1);
         send(tbl[g].w1, 1'b0, 1'b0);
         send(tbl[g].w2, 1'b0, (g % 2) == 1);
      end
      idle();
      drain(PPF);
      chk("tbl_stalls", stall_cycles, 3);
      chk("tbl_count", q.size(), PPF);
      for (int g = 0; g < 4 && q.size() >= PPF; g++) begin
         for (int k = 0; k < 4; k++) begin
            logic [23:0] e;
            case (k)
               0: e = tbl[g].p0;
               1: e = tbl[g].p1;
               2: e = tbl[g].p2;
               default: e = tbl[g].p3;
            endcase
            chk("tbl_rgb", q[4 * g + k].rgb, e);
            chk("tbl_x", q[4 * g + k].x, (g % 2) * 4 + k);
            chk("tbl_y", q[4 * g + k].y, g / 2);
            chk("tbl_cycle", q[4 * g + k].cyc - q[4 * g].cyc, k);
         end
      end
      chk("tbl_sof0", q.size() > 0 ? q[0].sof : 1'b0, 1);
      chk("tbl_eol7", q.size() > 7 ? q[7].eol : 1'b0, 1);
      q.delete();
      chk("fc_1", frame_count, 1);
      chk("sof_0", sof_err_count, 0);
      chk("eol_0", eol_err_count, 0);

      // Early tuser in the middle of a frame resynchronises.
      send_frame(5, 7, 1'b0);
      drain(9);
      q.delete();
      send_frame(9, WPF, 1'b0);
      check_frame(9);
      chk("resync_sof_err", sof_err_count, 1);
      chk("resync_fc", frame_count, 2);
      chk("resync_eol", eol_err_count, 0);

      // Missing tlast on line 0, early tlast on line 1.
      send_frame(11, WPF, 1'b1);
      check_frame(11);
      chk("eolfault_count", eol_err_count, 2);
      chk("eolfault_fc", frame_count, 3);

      // Missing tuser where a frame should start: drop and hunt.
      send(gword(13, 0), 1'b0, 1'b0);
      idle();
      drain(1);
      chk("nosof_err", sof_err_count, 2);
      chk("nosof_locked", locked, 0);
      chk("nosof_pixels", q.size(), 0);

      // Random downstream back-pressure.
      rand_mode = 1'b1;
      send_frame(21, WPF, 1'b0);
      check_frame(21);
      rand_mode = 1'b0;
      chk("rand_fc", frame_count, 4);
      chk("rand_locked", locked, 1);

      // Reset in the middle of a frame clears everything.
      send_frame(30, 4, 1'b0);
      repeat (2) @(posedge clk);
      do_reset();
      q.delete();
      send_frame(31, WPF, 1'b0);
      check_frame(31);
      chk("post_reset_fc", frame_count, 1);
      chk("post_reset_errs", {sof_err_count, eol_err_count}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
